// File: rtl/mipi_rx_lane_sync_ctrl.sv
// Link-level MIPI RX lane sync controller: aligner reset sequencing, SYNC lock supervision, skew measurement.
// Optional MIPI_RX_SYNC_STATS_EN adds saturating lock/error counters.
module mipi_rx_lane_sync_ctrl #(
  parameter int unsigned LANES         = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_TIMEOUT  = 32,
  parameter int unsigned MAX_SKEW      = 3,
  parameter int unsigned DLY_W         = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   lp_state_i,
  input  logic [LANES-1:0]       aligner_valid_i,
  output logic                   aligner_reset_o,
  output logic                   lanes_valid_o,
  output logic [LANES*DLY_W-1:0] lane_delay_o,
  output logic                   sync_err_o
`ifdef MIPI_RX_SYNC_STATS_EN
  ,
  output logic [7:0]             lock_count_o,
  output logic [7:0]             err_count_o
`endif
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned HW = $clog2(SYNC_TIMEOUT);
  localparam int unsigned CW = DLY_W + 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] HUNT_LAST   = HW'(SYNC_TIMEOUT - 1);
  localparam logic [CW-1:0] SKEW_LIMIT  = CW'(MAX_SKEW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_HUNT,
    S_LOCKED,
    S_ERROR
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [HW-1:0]          hunt_q, hunt_d;
  logic [LANES-1:0]       arr_q, arr_d;
  logic [CW-1:0]          dly_q [LANES];
  logic [CW-1:0]          dly_d [LANES];
  logic [CW-1:0]          dly_inc [LANES];
  logic [LANES-1:0]       arr_now;
  logic                   skew_over;
  logic                   rst_q, rst_d;
  logic                   valid_q, valid_d;
  logic [LANES*DLY_W-1:0] delay_q, delay_d;
  logic                   err_q, err_d;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    hunt_d    = hunt_q;
    arr_d     = arr_q;
    dly_d     = dly_q;
    delay_d   = delay_q;
    arr_now   = arr_q | aligner_valid_i;
    skew_over = 1'b0;
    // dly_inc is the skew count including this cycle; a lane arriving now reads 0
    for (int unsigned k = 0; k < LANES; k++) begin
      dly_inc[k] = dly_q[k] + CW'(arr_q[k]);
      if (dly_inc[k] == SKEW_LIMIT) skew_over = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!lp_state_i) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_HUNT;
          hunt_d  = '0;
          arr_d   = '0;
          for (int unsigned k = 0; k < LANES; k++) dly_d[k] = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_HUNT: begin
        arr_d = arr_now;
        dly_d = dly_inc;
        if (hunt_q != HUNT_LAST) hunt_d = hunt_q + 1'b1;
        if (skew_over) begin
          state_d = S_ERROR;
        end else if (&arr_now) begin
          state_d = S_LOCKED;
          for (int unsigned k = 0; k < LANES; k++)
            delay_d[k*DLY_W +: DLY_W] = dly_inc[k][DLY_W-1:0];
        end else if (arr_now == '0 && hunt_q == HUNT_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_LOCKED: begin
        if (!(&aligner_valid_i)) state_d = S_ERROR;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    if (lp_state_i) state_d = S_IDLE;

    // outputs registered from the next state so they line up with the state register
    rst_d   = !(state_d == S_HUNT || state_d == S_LOCKED);
    valid_d = (state_d == S_LOCKED);
    if (state_d != S_LOCKED) delay_d = '0;
    err_d   = (state_d == S_ERROR) && (state_q != S_ERROR);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      hunt_q   <= '0;
      arr_q    <= '0;
      for (int unsigned k = 0; k < LANES; k++) dly_q[k] <= '0;
      rst_q    <= 1'b1;
      valid_q  <= 1'b0;
      delay_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      hunt_q   <= hunt_d;
      arr_q    <= arr_d;
      dly_q    <= dly_d;
      rst_q    <= rst_d;
      valid_q  <= valid_d;
      delay_q  <= delay_d;
      err_q    <= err_d;
    end
  end

  assign aligner_reset_o = rst_q;
  assign lanes_valid_o   = valid_q;
  assign lane_delay_o    = delay_q;
  assign sync_err_o      = err_q;

`ifdef MIPI_RX_SYNC_STATS_EN
  logic [7:0] lock_cnt_q, err_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (state_q == S_HUNT && state_d == S_LOCKED && lock_cnt_q != '1)
        lock_cnt_q <= lock_cnt_q + 1'b1;
      if (err_d && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign lock_count_o = lock_cnt_q;
  assign err_count_o  = err_cnt_q;
`endif

endmodule
